// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: side encodings, pointer width
// helper and Gray/binary conversions. Used by pointer, flag and sync blocks.
package fifo_pkg;

    // Side encodings for the STATE parameter
    localparam int unsigned EMPTY_SIDE = 0;
    localparam int unsigned FULL_SIDE  = 1;

    // Default RAM address width
    localparam int unsigned DEF_ADDR_WIDTH = 4;

    // Pointers carry one extra wrap bit over the RAM address
    function automatic int unsigned ptr_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    localparam int unsigned PTR_WIDTH = ptr_width(DEF_ADDR_WIDTH);

    // Binary to reflected Gray
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary as a prefix XOR running down from the MSB
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_gray_ctr.sv
// Binary + Gray pointer register pair with enable.
// Ports: clk, rst_n (sync, active-low), en (advance), bin, gray (both registered).
module gray_ctr
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    logic [WIDTH-1:0] bin_inc;

    assign bin_inc = bin + WIDTH'(1);

    // Both registers move together so gray always equals bin2gray(bin)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin  <= '0;
            gray <= '0;
        end else if (en) begin
            bin  <= bin_inc;
            gray <= WIDTH'(bin2gray(32'(bin_inc)));
        end
    end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Per-domain FIFO pointer controller. STATE=1 is the write/full side,
// STATE=0 the read/empty side.
// Ports: clk, rst_n (sync, active-low), inc (access request), flag (full/empty),
//        ptr_rmt (synchronized remote Gray pointer), addr (RAM address),
//        ptr_bin/ptr_gray (local pointers), level (occupancy),
//        almost (almost-full/empty), err (sticky overflow/underflow).
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned STATE      = 0,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned ALMOST_TH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    input  logic                  flag,
    input  logic [ADDR_WIDTH:0]   ptr_rmt,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH:0]   ptr_bin,
    output logic [ADDR_WIDTH:0]   ptr_gray,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost,
    output logic                  err
);

    localparam int unsigned PW    = ptr_width(ADDR_WIDTH);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    if (STATE != EMPTY_SIDE && STATE != FULL_SIDE) begin : g_bad_state
        $error("fifo_ptr_ctrl: STATE must be 0 or 1");
    end

    logic          acc_c;
    logic [PW-1:0] rmt_bin_c;
    logic [PW-1:0] rmt_bin_q;
    logic [PW-1:0] level_next_c;
    logic          almost_next_c;

    assign acc_c     = inc & ~flag;
    assign rmt_bin_c = PW'(gray2bin(32'(ptr_rmt)));

    gray_ctr #(
        .WIDTH (PW)
    ) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (acc_c),
        .bin   (ptr_bin),
        .gray  (ptr_gray)
    );

    // Address is the low bits of the registered binary pointer
    assign addr = ptr_bin[ADDR_WIDTH-1:0];

    // Occupancy from last edge's local pointer and registered remote pointer
    always_comb begin
        level_next_c  = '0;
        almost_next_c = 1'b0;
        if (STATE == FULL_SIDE) begin
            level_next_c  = ptr_bin - rmt_bin_q;
            almost_next_c = (level_next_c >= PW'(DEPTH - ALMOST_TH));
        end else begin
            level_next_c  = rmt_bin_q - ptr_bin;
            almost_next_c = (level_next_c <= PW'(ALMOST_TH));
        end
    end

    // Remote decode, level/almost and sticky misuse error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rmt_bin_q <= '0;
            level     <= '0;
            almost    <= (STATE == EMPTY_SIDE);
            err       <= 1'b0;
        end else begin
            rmt_bin_q <= rmt_bin_c;
            level     <= level_next_c;
            almost    <= almost_next_c;
            err       <= err | (inc & flag);
        end
    end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl: one write-side and one read-side instance.
module tb_fifo_ptr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       w_inc, w_flag, r_inc, r_flag;
    logic [4:0] w_rmt, r_rmt;
    logic [3:0] w_addr, r_addr;
    logic [4:0] w_bin, w_gray, w_level, r_bin, r_gray, r_level;
    logic       w_almost, w_err, r_almost, r_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fifo_ptr_ctrl #(.STATE(1), .ADDR_WIDTH(4), .ALMOST_TH(2)) u_wr (
        .clk(clk), .rst_n(rst_n), .inc(w_inc), .flag(w_flag), .ptr_rmt(w_rmt),
        .addr(w_addr), .ptr_bin(w_bin), .ptr_gray(w_gray), .level(w_level),
        .almost(w_almost), .err(w_err)
    );

    fifo_ptr_ctrl #(.STATE(0), .ADDR_WIDTH(4), .ALMOST_TH(2)) u_rd (
        .clk(clk), .rst_n(rst_n), .inc(r_inc), .flag(r_flag), .ptr_rmt(r_rmt),
        .addr(r_addr), .ptr_bin(r_bin), .ptr_gray(r_gray), .level(r_level),
        .almost(r_almost), .err(r_err)
    );

    // Hand-written 5-bit Gray sequence
    localparam logic [4:0] GT [32] = '{
        5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110, 5'b00111, 5'b00101, 5'b00100,
        5'b01100, 5'b01101, 5'b01111, 5'b01110, 5'b01010, 5'b01011, 5'b01001, 5'b01000,
        5'b11000, 5'b11001, 5'b11011, 5'b11010, 5'b11110, 5'b11111, 5'b11101, 5'b11100,
        5'b10100, 5'b10101, 5'b10111, 5'b10110, 5'b10010, 5'b10011, 5'b10001, 5'b10000
    };

    typedef struct {
        int         cyc;
        int         side;
        logic [4:0] bin;
        logic [4:0] gray;
        logic [3:0] addr;
        logic [4:0] level;
        logic       almost;
        logic       err;
        string      name;
    } exp_t;

    exp_t sb[$];

    // Reference state per side (0 = read, 1 = write)
    logic [4:0] m_bin [2];
    logic [4:0] m_rq  [2];
    logic [4:0] m_lev [2];
    logic       m_alm [2];
    logic       m_err [2];

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (GT[i] == g) r = 5'(i);
        end
        return r;
    endfunction

    task automatic push(input int side, input logic [4:0] bin, input logic [4:0] gray,
                        input logic [4:0] lev, input logic alm, input logic er,
                        input string nm);
        exp_t e;
        e.cyc = cyc; e.side = side; e.bin = bin; e.gray = gray;
        e.addr = bin[3:0]; e.level = lev; e.almost = alm; e.err = er; e.name = nm;
        sb.push_back(e);
    endtask

    // Advance one edge: update the reference from the applied inputs, then queue expectations
    task automatic step();
        logic [4:0] nbin [2];
        logic [4:0] nrq  [2];
        logic [4:0] nlev [2];
        logic       nalm [2];
        logic       nerr [2];
        logic       inc, flg;
        logic [4:0] rmt;
        for (int s = 0; s < 2; s++) begin
            inc = (s == 1) ? w_inc  : r_inc;
            flg = (s == 1) ? w_flag : r_flag;
            rmt = (s == 1) ? w_rmt  : r_rmt;
            if (!rst_n) begin
                nbin[s] = '0; nrq[s] = '0; nlev[s] = '0;
                nalm[s] = (s == 0); nerr[s] = 1'b0;
            end else begin
                nlev[s] = (s == 1) ? 5'(m_bin[s] - m_rq[s]) : 5'(m_rq[s] - m_bin[s]);
                nalm[s] = (s == 1) ? (nlev[s] >= 5'd14) : (nlev[s] <= 5'd2);
                nbin[s] = (inc && !flg) ? 5'(m_bin[s] + 5'd1) : m_bin[s];
                nrq[s]  = g2b(rmt);
                nerr[s] = m_err[s] | (inc & flg);
            end
        end
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            m_bin[s] = nbin[s]; m_rq[s] = nrq[s]; m_lev[s] = nlev[s];
            m_alm[s] = nalm[s]; m_err[s] = nerr[s];
            push(s, m_bin[s], GT[m_bin[s]], m_lev[s], m_alm[s], m_err[s], "model");
        end
    endtask

    // Monitor: compare queued expectations against the DUT at the falling edge
    logic [4:0] prev_wg, prev_rg;
    logic       prev_rst = 1'b0;

    always @(negedge clk) begin
        exp_t       e;
        logic [4:0] ab, ag, al;
        logic [3:0] aa;
        logic       am, ae;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.side == 1) begin
                ab = w_bin; ag = w_gray; aa = w_addr; al = w_level; am = w_almost; ae = w_err;
            end else begin
                ab = r_bin; ag = r_gray; aa = r_addr; al = r_level; am = r_almost; ae = r_err;
            end
            checks++;
            if (ab !== e.bin || ag !== e.gray || aa !== e.addr || al !== e.level ||
                am !== e.almost || ae !== e.err) begin
                errors++;
                $display("FAIL %s side%0d cyc%0d got bin=%0d gray=%b addr=%0d level=%0d almost=%b err=%b need bin=%0d gray=%b addr=%0d level=%0d almost=%b err=%b",
                         e.name, e.side, e.cyc, ab, ag, aa, al, am, ae,
                         e.bin, e.gray, e.addr, e.level, e.almost, e.err);
            end
        end
        // Gray pointers must move by at most one bit outside of reset
        if (prev_rst) begin
            checks++;
            if ($countones(prev_wg ^ w_gray) > 1 || $countones(prev_rg ^ r_gray) > 1) begin
                errors++;
                $display("FAIL gray_step cyc%0d got wr %b->%b rd %b->%b need <=1 bit change",
                         cyc, prev_wg, w_gray, prev_rg, r_gray);
            end
        end
        prev_wg  = w_gray;
        prev_rg  = r_gray;
        prev_rst = rst_n;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc%0d got no finish need finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            m_bin[s] = '0; m_rq[s] = '0; m_lev[s] = '0; m_alm[s] = 1'b0; m_err[s] = 1'b0;
        end
        rst_n = 1'b0;
        w_inc = 1'b1; w_flag = 1'b0; w_rmt = '0;
        r_inc = 1'b1; r_flag = 1'b0; r_rmt = '0;

        // Reset held with requests active
        step(); step();
        push(1, 5'd0, 5'b00000, 5'd0, 1'b0, 1'b0, "reset_wr");
        push(0, 5'd0, 5'b00000, 5'd0, 1'b1, 1'b0, "reset_rd");
        rst_n = 1'b1; w_inc = 1'b0; r_inc = 1'b0;
        step();

        // Sixteen writes into an empty FIFO
        for (int i = 0; i < 16; i++) begin
            w_inc = 1'b1;
            step();
            if (i == 7) push(1, 5'd8, 5'b01100, 5'd7, 1'b0, 1'b0, "gray_7_to_8");
        end
        push(1, 5'd16, 5'b11000, 5'd15, 1'b1, 1'b0, "after_16");
        w_inc = 1'b0;
        step();
        push(1, 5'd16, 5'b11000, 5'd16, 1'b1, 1'b0, "level_16");

        // Write while full: pointers hold, error sticks
        w_flag = 1'b1; w_inc = 1'b1;
        step();
        push(1, 5'd16, 5'b11000, 5'd16, 1'b1, 1'b1, "overflow");
        w_flag = 1'b0; w_inc = 1'b0;
        step(); step();
        push(1, 5'd16, 5'b11000, 5'd16, 1'b1, 1'b1, "err_sticky");

        // Wrap: 16 more to reach zero, then a full 32-accept lap
        w_inc = 1'b1;
        for (int i = 0; i < 16; i++) step();
        push(1, 5'd0, 5'b00000, 5'd31, 1'b1, 1'b1, "wrap_0");
        for (int i = 0; i < 32; i++) step();
        push(1, 5'd0, 5'b00000, 5'd31, 1'b1, 1'b1, "wrap_32");
        w_inc = 1'b0;
        step();

        // Read side sees remote pointer Gray 00111 (binary 5)
        r_rmt = 5'b00111;
        step(); step();
        push(0, 5'd0, 5'b00000, 5'd5, 1'b0, 1'b0, "rd_level_5");
        r_inc = 1'b1;
        for (int i = 0; i < 3; i++) step();
        r_inc = 1'b0;
        step();
        push(0, 5'd3, 5'b00010, 5'd2, 1'b1, 1'b0, "rd_level_2");

        // Read while empty: underflow error
        r_flag = 1'b1; r_inc = 1'b1;
        step();
        push(0, 5'd3, 5'b00010, 5'd2, 1'b1, 1'b1, "underflow");
        r_flag = 1'b0; r_inc = 1'b0;

        // Mid-operation reset with write held
        w_inc = 1'b1;
        for (int i = 0; i < 9; i++) step();
        push(1, 5'd9, 5'b01101, 5'd8, 1'b0, 1'b1, "pre_reset_9");
        rst_n = 1'b0;
        step();
        push(1, 5'd0, 5'b00000, 5'd0, 1'b0, 1'b0, "mid_reset_wr");
        push(0, 5'd0, 5'b00000, 5'd0, 1'b1, 1'b0, "mid_reset_rd");
        rst_n = 1'b1;
        step();
        push(1, 5'd1, 5'b00001, 5'd0, 1'b0, 1'b0, "resume_1");
        step();
        push(1, 5'd2, 5'b00011, 5'd1, 1'b0, 1'b0, "resume_2");
        w_inc = 1'b0;
        step();

        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending need 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_ptr_ctrl.md
Name: fifo_ptr_ctrl

Overview:
Per-domain pointer controller for the asynchronous FIFO; one instance in the write domain (STATE=1) and one in the read domain (STATE=0).
- Accepts access requests and advances the extended binary and Gray pointers.
- Its Gray output is the local pointer consumed by this domain's flag block and the pointer crossed to the remote domain.
- Decodes the synchronized remote Gray pointer into an occupancy level, almost-flag and sticky misuse error.

Parameters:
STATE, 0, 0 = read/empty side (rd_clk domain), 1 = write/full side (wr_clk domain)
ADDR_WIDTH, 4, RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
ALMOST_TH, 2, almost-flag threshold in entries

Ports:
clk  in  1  domain clock (wr_clk for STATE=1, rd_clk for STATE=0)
rst_n  in  1  reset, synchronous, active-low
inc  in  1  access request (write enable for STATE=1, read enable for STATE=0)
flag  in  1  registered full (STATE=1) or empty (STATE=0) from this domain's flag block
ptr_rmt  in  ADDR_WIDTH+1  synchronized remote Gray pointer
addr  out  ADDR_WIDTH  RAM address, equals ptr_bin[ADDR_WIDTH-1:0]
ptr_bin  out  ADDR_WIDTH+1  registered local binary pointer
ptr_gray  out  ADDR_WIDTH+1  registered local Gray pointer (to flag block and to remote synchronizer)
level  out  ADDR_WIDTH+1  registered occupancy, 0..DEPTH
almost  out  1  registered almost-full (STATE=1) or almost-empty (STATE=0)
err  out  1  sticky overflow (STATE=1) or underflow (STATE=0)

Behaviour:
- Clock and reset: clock clk; reset rst_n, synchronous, active-low.
- Reset values: ptr_bin=0, ptr_gray=0, addr=0, level=0, err=0, internal rmt_bin_q=0. almost=1 when STATE=0; almost=0 when STATE=1.
- Reset mid-operation returns all state to these reset values at the next edge with rst_n=0. Any inc in that cycle is ignored.
- Acceptance: acc = inc & ~flag.
- On acc, ptr_bin <= ptr_bin+1, modulo 2**(ADDR_WIDTH+1).
- On acc, ptr_gray <= nb ^ (nb>>1), where nb is the incremented binary value. Both registers update at the same edge; latency 1 cycle.
- Gray rule: ptr_gray changes in at most one bit per cycle. It is driven only by a flop, never by logic.
- Wrap-around: after 2**(ADDR_WIDTH+1) accepts, ptr_bin=0 and ptr_gray=0. addr wraps every DEPTH accepts.
- Misuse: inc & flag leaves the pointers unchanged and sets err <= 1 at that edge. err clears only on reset.
- Remote decode: rmt_bin = Gray-to-binary of ptr_rmt, computed as a prefix XOR from the MSB. It is registered into rmt_bin_q every cycle.
- Level: every edge, level is computed from the current registered values.
  - STATE=1: level <= ptr_bin - rmt_bin_q.
  - STATE=0: level <= rmt_bin_q - ptr_bin.
  - Arithmetic is ADDR_WIDTH+1 bits, modulo.
- Almost: updated at the same edge as level, from the same operands.
  - STATE=1: almost <= (level_next >= DEPTH-ALMOST_TH).
  - STATE=0: almost <= (level_next <= ALMOST_TH).
- Latency:
  - A local accept at edge k is reflected in level and almost at edge k+1.
  - A ptr_rmt change sampled at edge j is reflected at edge j+1.
- Level is conservative by design and can lag true occupancy by the synchronizer depth plus 2 cycles.
- Simultaneous accept and remote change: each term uses its value registered at the previous edge. No priority is needed.
- Invalid STATE is a compile-time error.

Decomposition:
- Shared package fifo_pkg holds:
  - localparam PTR_WIDTH(ADDR_WIDTH) = ADDR_WIDTH+1
  - function bin2gray
  - function gray2bin
  - STATE encodings EMPTY_SIDE=0 and FULL_SIDE=1
- The flag block and the synchronizer bench also use fifo_pkg.
- One natural sub-module: gray_ctr. It holds the binary+Gray register pair with enable, shared by both STATE variants. The level/almost logic stays in fifo_ptr_ctrl.

Test Plan:
1. Reset, STATE=0 and STATE=1: hold rst_n=0 for 2 cycles with inc=1 -> all outputs 0, except almost=1 for STATE=0; err=0.
2. STATE=1, ptr_rmt=0, flag=0, 16 single-cycle inc:
   - ptr_gray follows 00000, 00001, 00011, 00010, …; step 7->8 gives 00100->01100, exactly one bit change per accept.
   - Final values: ptr_bin=16, ptr_gray=11000, addr=0.
   - level reaches 16 one cycle later; almost asserts one cycle after the 14th accept.
3. STATE=1, flag=1, inc=1 -> ptr_bin and ptr_gray unchanged, err=1 next edge. err remains 1 after flag=0 until rst_n=0.
4. Wrap: 32 accepts with flag=0 -> ptr_bin=0, ptr_gray=00000, addr=0. Every intermediate Gray transition has Hamming distance 1.
5. STATE=0, ptr_rmt set to 00111 (binary 5):
   - Two edges later level=5, almost=0.
   - After 3 read accepts: level=2 and almost=1, one edge after the 3rd accept.
6. Reset mid-operation at ptr_bin=9 with inc=1 held -> next edge all outputs at reset values. Counting resumes from 0 on the first edge after rst_n=1.
